// File: rtl/fig_01_rom_port.sv
// ROM-side responder for instruction fetch and the GSU ROM buffer: arbitrates
// fetch/buffer reads, applies clock-speed wait states and returns the ROM byte.
module fig_01_rom_port #(
  parameter int WAIT_SLOW = 5,
  parameter int WAIT_FAST = 3
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ron,
  input  logic        i_clsr,
  input  logic        i_fetch_req,
  input  logic [23:0] i_fetch_addr,
  input  logic        i_data_req,
  input  logic [23:0] i_data_addr,
  input  logic [23:0] i_ha,
  input  logic [7:0]  i_rom_d,
  output logic [23:0] o_rom_a,
  output logic        o_romrdy,
  output logic [7:0]  o_instr_out,
  output logic [7:0]  o_romb_data,
  output logic        o_romb_valid,
  output logic        o_busy,
  output logic        o_state
);

  // Handshake: fetch_req is a level held until the one-cycle romrdy pulse;
  // data_req is a one-cycle pulse whose result is flagged by romb_valid.

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  localparam logic [7:0] CNT_SLOW = 8'(WAIT_SLOW - 1);
  localparam logic [7:0] CNT_FAST = 8'(WAIT_FAST - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_src_data;
  logic        r_stale;
  logic        r_data_pend;
  logic [23:0] r_pend_addr;
  logic [23:0] r_rom_a;
  logic        r_romrdy;
  logic [7:0]  r_instr_out;
  logic [7:0]  r_romb_data;
  logic        r_romb_valid;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_src_data   <= 1'b0;
      r_stale      <= 1'b0;
      r_data_pend  <= 1'b0;
      r_pend_addr  <= '0;
      r_rom_a      <= '0;
      r_romrdy     <= 1'b0;
      r_instr_out  <= '0;
      r_romb_data  <= '0;
      r_romb_valid <= 1'b0;
    end else begin
      r_romrdy <= 1'b0;
      if (i_data_req) begin
        r_data_pend  <= 1'b1;
        r_pend_addr  <= i_data_addr;
        r_romb_valid <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (!i_ron) begin
            r_rom_a <= i_ha;
          // The romrdy cycle is the fetch unit's turnaround; its fetch_req is stale.
          end else if (i_fetch_req && !r_romrdy) begin
            r_rom_a    <= i_fetch_addr;
            r_src_data <= 1'b0;
            r_cnt      <= i_clsr ? CNT_FAST : CNT_SLOW;
            r_stale    <= 1'b0;
            r_state    <= ACCESS;
          end else if (r_data_pend) begin
            r_rom_a    <= r_pend_addr;
            r_src_data <= 1'b1;
            r_cnt      <= i_clsr ? CNT_FAST : CNT_SLOW;
            r_stale    <= i_data_req;
            r_state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (!i_ron) begin
            r_rom_a <= i_ha;
            r_stale <= 1'b0;
            r_state <= IDLE;
          end else if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
            if (i_data_req && r_src_data) r_stale <= 1'b1;
          end else begin
            if (!r_src_data) begin
              r_instr_out <= i_rom_d;
              r_romrdy    <= 1'b1;
            // A newer data_req supersedes this byte; data_pend stays set for the retry.
            end else if (!r_stale && !i_data_req) begin
              r_romb_data  <= i_rom_d;
              r_romb_valid <= 1'b1;
              r_data_pend  <= 1'b0;
            end
            r_stale <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_rom_a      = r_rom_a;
  assign o_romrdy     = r_romrdy;
  assign o_instr_out  = r_instr_out;
  assign o_romb_data  = r_romb_data;
  assign o_romb_valid = r_romb_valid;
  assign o_busy       = (r_state == ACCESS) | r_data_pend;
  assign o_state      = r_state;

endmodule

// File: tb/tb_fig_01_rom_port.sv
// Bench for fig_01_rom_port: directed fetch / ROM-buffer scenarios with a
// cycle-stamped expected queue checked by a monitor on the falling edge.
module tb_fig_01_rom_port;

  logic        clk;
  logic        i_reset;
  logic        i_ron;
  logic        i_clsr;
  logic        i_fetch_req;
  logic [23:0] i_fetch_addr;
  logic        i_data_req;
  logic [23:0] i_data_addr;
  logic [23:0] i_ha;
  logic [7:0]  i_rom_d;
  logic [23:0] o_rom_a;
  logic        o_romrdy;
  logic [7:0]  o_instr_out;
  logic [7:0]  o_romb_data;
  logic        o_romb_valid;
  logic        o_busy;
  logic        o_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [39:0] exp_q[$];   // {romrdy cycle, instr byte}
  logic [7:0]  romb_q[$];  // expected romb_data on each romb_valid rise
  logic        prev_romb_valid = 1'b0;

  fig_01_rom_port #(.WAIT_SLOW(5), .WAIT_FAST(3)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_ron(i_ron), .i_clsr(i_clsr),
    .i_fetch_req(i_fetch_req), .i_fetch_addr(i_fetch_addr),
    .i_data_req(i_data_req), .i_data_addr(i_data_addr), .i_ha(i_ha),
    .i_rom_d(i_rom_d), .o_rom_a(o_rom_a), .o_romrdy(o_romrdy),
    .o_instr_out(o_instr_out), .o_romb_data(o_romb_data),
    .o_romb_valid(o_romb_valid), .o_busy(o_busy), .o_state(o_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rom_byte(input logic [23:0] a);
    case (a)
      24'h018000: rom_byte = 8'hA5;
      24'h000010: rom_byte = 8'h3C;
      24'h000011: rom_byte = 8'h4D;
      24'h000100: rom_byte = 8'h11;
      24'h000200: rom_byte = 8'h22;
      default:    rom_byte = a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endcase
  endfunction

  assign i_rom_d = rom_byte(o_rom_a);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [39:0] e;
    if (o_romrdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("romrdy_spurious", 32'(o_romrdy), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("romrdy_cycle", 32'(cyc), e[39:8]);
        check("instr_out", 32'(o_instr_out), 32'(e[7:0]));
      end
    end
    if (o_romb_valid === 1'b1 && !prev_romb_valid) begin
      if (romb_q.size() == 0) check("romb_spurious", 32'(o_romb_valid), 32'd0);
      else check("romb_data", 32'(o_romb_data), 32'(romb_q.pop_front()));
    end
    prev_romb_valid = (o_romb_valid === 1'b1);
  end

  // driver tasks
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_fetch(input logic [23:0] addr, input int w);
    int start;
    bit seen;
    start = (o_romrdy === 1'b1) ? cyc + 1 : cyc;
    i_fetch_req  = 1'b1;
    i_fetch_addr = addr;
    exp_q.push_back({32'(start + w + 1), rom_byte(addr)});
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step();
      if (cyc == start + 1) check("fetch_rom_a", o_rom_a, 32'(addr));
      if (o_romrdy === 1'b1) seen = 1'b1;
    end
    i_fetch_req = 1'b0;
    check("fetch_timeout", 32'(seen), 32'd1);
  endtask

  task automatic pulse_data(input logic [23:0] addr, input logic [7:0] exp_byte);
    i_data_req  = 1'b1;
    i_data_addr = addr;
    romb_q.push_back(exp_byte);
    step();
    i_data_req = 1'b0;
  endtask

  task automatic wait_romb(input int exp_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step();
      if (o_romb_valid === 1'b1) begin
        seen = 1'b1;
        check("romb_cycle", 32'(cyc), 32'(exp_cyc));
        check("busy_at_romb", 32'(o_busy), 32'd0);
      end
    end
    check("romb_timeout", 32'(seen), 32'd1);
  endtask

  initial begin
    int n, a, r, r2;
    bit seen;
    i_reset = 1'b1; i_ron = 1'b0; i_clsr = 1'b0;
    i_fetch_req = 1'b0; i_fetch_addr = '0;
    i_data_req = 1'b0; i_data_addr = '0; i_ha = 24'h00FFFF;
    repeat (3) step();
    check("rst_rom_a", o_rom_a, 32'd0);
    check("rst_romrdy", 32'(o_romrdy), 32'd0);
    check("rst_instr", 32'(o_instr_out), 32'd0);
    check("rst_romb_data", 32'(o_romb_data), 32'd0);
    check("rst_romb_valid", 32'(o_romb_valid), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);

    // slow fetch
    i_reset = 1'b0; i_ron = 1'b1; i_clsr = 1'b0;
    do_fetch(24'h018000, 5);
    step();

    // fast back-to-back fetches
    i_clsr = 1'b1;
    do_fetch(24'h000010, 3);
    do_fetch(24'h000011, 3);
    repeat (2) step();

    // fetch and data request together: fetch wins, data follows
    n = cyc;
    fork
      do_fetch(24'h000020 + 24'($urandom_range(0, 15)), 3);
      pulse_data(24'h7F1234, rom_byte(24'h7F1234));
    join
    step();
    check("data_rom_a", o_rom_a, 32'h7F1234);
    check("data_busy", 32'(o_busy), 32'd1);
    wait_romb(n + 8);
    repeat (2) step();

    // data request superseded mid-access
    a = cyc;
    i_data_req = 1'b1; i_data_addr = 24'h000100;
    step();
    i_data_req = 1'b0;
    check("romb_valid_cleared", 32'(o_romb_valid), 32'd0);
    repeat (2) step();
    pulse_data(24'h000200, 8'h22);
    step();
    check("stale_discard", 32'(o_romb_valid), 32'd0);
    check("stale_busy", 32'(o_busy), 32'd1);
    step();
    check("retry_rom_a", o_rom_a, 32'h000200);
    wait_romb(a + 9);
    repeat (2) step();

    // host owns the bus, then abort and full-length retry
    i_clsr = 1'b0;
    i_ron = 1'b0; i_ha = 24'h00C123;
    step();
    check("host_rom_a", o_rom_a, 32'h00C123);
    i_fetch_req = 1'b1; i_fetch_addr = 24'h123456;
    repeat (3) step();
    check("host_busy", 32'(o_busy), 32'd0);
    r = cyc;
    i_ron = 1'b1;
    step();
    check("ron_rise_rom_a", o_rom_a, 32'h123456);
    step();
    i_ron = 1'b0; i_ha = 24'h00D000;
    step();
    check("abort_rom_a", o_rom_a, 32'h00D000);
    check("abort_busy", 32'(o_busy), 32'd0);
    repeat (2) step();
    r2 = cyc;
    i_ron = 1'b1;
    exp_q.push_back({32'(r2 + 6), rom_byte(24'h123456)});
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step();
      if (o_romrdy === 1'b1) seen = 1'b1;
    end
    i_fetch_req = 1'b0;
    check("retry_timeout", 32'(seen), 32'd1);
    check("retry_after_abort", 32'(r2 - r), 32'd5);
    repeat (2) step();

    // reset in the middle of an access with a data request pending
    i_fetch_req = 1'b1; i_fetch_addr = 24'h00ABCD;
    i_data_req = 1'b1; i_data_addr = 24'h000300;
    step();
    i_data_req = 1'b0;
    step();
    i_reset = 1'b1; i_fetch_req = 1'b0;
    step();
    i_reset = 1'b0;
    check("mid_rst_rom_a", o_rom_a, 32'd0);
    check("mid_rst_instr", 32'(o_instr_out), 32'd0);
    check("mid_rst_romb_data", 32'(o_romb_data), 32'd0);
    check("mid_rst_romb_valid", 32'(o_romb_valid), 32'd0);
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    repeat (12) step();
    check("post_rst_busy", 32'(o_busy), 32'd0);
    check("post_rst_romb_valid", 32'(o_romb_valid), 32'd0);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("romb_q_drained", 32'(romb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
